terminal_console_arbiter: RTL and testbench

- Owns the single write port of the 80x30 terminal character buffer (addresses 0..2399).
- Shares that port between two requesters:
  - the debugger scanner, which streams one character per cycle;
  - a console character stream, which has a valid/ready handshake.
- The console is a cursor-based text window in rows CON_ROW_FIRST..CON_ROW_LAST. It handles newline, carriage return and form-feed clear, and wraps back to the first row with a row clear.
- The block sits between the debugger, the CPU-side console MMIO and the terminal buffer.

---
 rtl/terminal_pkg.sv | 22 ++
 rtl/terminal_write_arbiter.sv | 62 ++++++
 rtl/terminal_console_arbiter.sv | 144 ++++++++++++++
 tb/tb_terminal_console_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/terminal_pkg.sv
`default_nettype none
// terminal_pkg: terminal geometry, console control codes and console FSM states.
// Rev 1.0
package terminal_pkg;
   localparam int          TERM_COLUMNS  = 80;
   localparam int          TERM_ROWS     = 30;
   localparam logic [11:0] TERM_MAX_ADDR = 12'd2399;

   localparam logic [7:0] CHAR_LF       = 8'h0A;
   localparam logic [7:0] CHAR_CR       = 8'h0D;
   localparam logic [7:0] CHAR_FF       = 8'h0C;
   localparam logic [7:0] CHAR_BLANK    = 8'h00;
   localparam logic [7:0] CHAR_PRINT_LO = 8'h20;
   localparam logic [7:0] CHAR_PRINT_HI = 8'h7E;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_CLEAR_ALL = 2'd1,
      ST_CLEAR_ROW = 2'd2
   } con_state_t;
endpackage
`default_nettype wire

// File: rtl/terminal_write_arbiter.sv
`default_nettype none
// terminal_write_arbiter: console/debugger priority with burst limit, registered write port.
// Rev 1.0
module terminal_write_arbiter #(
   parameter int MAX_CON_BURST = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        con_req,
   input  logic [11:0] con_addr,
   input  logic [7:0]  con_data,
   input  logic        dbg_write,
   input  logic [11:0] dbg_addr,
   input  logic [7:0]  dbg_data,
   output logic        con_grant,
   output logic        dbg_ready,
   output logic [11:0] term_addr,
   output logic        term_write,
   output logic [7:0]  term_data
);
   localparam int            BW        = $clog2(MAX_CON_BURST + 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_CON_BURST);

   logic [BW-1:0] burst_cnt;
   logic          burst_full;
   logic          dbg_grant;

   assign burst_full = (burst_cnt == BURST_MAX);
   assign con_grant  = con_req && !(dbg_write && burst_full);
   assign dbg_grant  = dbg_write && !con_grant;
   assign dbg_ready  = !con_req || dbg_grant;

   // The counter only measures how long a waiting debugger has been starved.
   always_ff @(posedge clock) begin
      if (reset) begin
         burst_cnt <= '0;
      end else if (!dbg_write || (dbg_grant && con_req)) begin
         burst_cnt <= '0;
      end else if (con_grant) begin
         burst_cnt <= burst_cnt + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         term_addr  <= '0;
         term_write <= 1'b0;
         term_data  <= '0;
      end else if (con_grant) begin
         term_addr  <= con_addr;
         term_write <= 1'b1;
         term_data  <= con_data;
      end else if (dbg_grant) begin
         term_addr  <= dbg_addr;
         term_write <= 1'b1;
         term_data  <= dbg_data;
      end else begin
         term_write <= 1'b0;
      end
   end
endmodule
`default_nettype wire

// File: rtl/terminal_console_arbiter.sv
`default_nettype none
// terminal_console_arbiter: cursor console window sharing the terminal write port with the debugger.
// Rev 1.0
module terminal_console_arbiter
   import terminal_pkg::*;
#(
   parameter int COLUMNS       = TERM_COLUMNS,
   parameter int ROWS          = TERM_ROWS,
   parameter int CON_ROW_FIRST = 16,
   parameter int CON_ROW_LAST  = 29,
   parameter int MAX_CON_BURST = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] dbg_addr,
   input  logic        dbg_write,
   input  logic [7:0]  dbg_data,
   output logic        dbg_ready,
   input  logic        con_valid,
   input  logic [7:0]  con_char,
   output logic        con_ready,
   output logic [11:0] term_addr,
   output logic        term_write,
   output logic [7:0]  term_data
);
   localparam int            RW          = $clog2(ROWS);
   localparam int            CW          = $clog2(COLUMNS);
   localparam logic [RW-1:0] ROW_FIRST   = RW'(CON_ROW_FIRST);
   localparam logic [RW-1:0] ROW_LAST    = RW'(CON_ROW_LAST);
   localparam logic [CW-1:0] COL_LAST    = CW'(COLUMNS - 1);
   localparam logic [11:0]   CLR_START   = 12'(CON_ROW_FIRST * COLUMNS);
   localparam logic [11:0]   CLR_ALL_END = 12'(CON_ROW_LAST * COLUMNS + COLUMNS - 1);

   con_state_t    state;
   logic [RW-1:0] row;
   logic [CW-1:0] col;
   logic          pending;
   logic [11:0]   pend_addr;
   logic [7:0]    pend_data;
   logic [11:0]   clr_addr;

   logic [11:0]   row_base;
   logic [11:0]   cursor_addr;
   logic [11:0]   clr_end;
   logic          row_wrap;
   logic [RW-1:0] row_next;
   logic          con_req;
   logic          con_grant;
   logic          con_take;
   logic          printable;
   logic [11:0]   con_addr;
   logic [7:0]    con_data;

   assign row_base    = 12'(row) * 12'(COLUMNS);
   assign cursor_addr = row_base + 12'(col);
   assign clr_end     = (state == ST_CLEAR_ALL) ? CLR_ALL_END : row_base + 12'(COLUMNS - 1);
   assign row_wrap    = (row == ROW_LAST);
   assign row_next    = row_wrap ? ROW_FIRST : row + 1'b1;

   assign con_ready = (state == ST_IDLE) && !pending;
   assign con_take  = con_valid && con_ready;
   assign printable = (con_char >= CHAR_PRINT_LO) && (con_char <= CHAR_PRINT_HI);
   assign con_req   = pending || (state != ST_IDLE);
   assign con_addr  = pending ? pend_addr : clr_addr;
   assign con_data  = pending ? pend_data : CHAR_BLANK;

   // con_take and con_grant are exclusive: a grant needs a console request, a take needs none.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_CLEAR_ALL;
         row       <= ROW_FIRST;
         col       <= '0;
         pending   <= 1'b0;
         pend_addr <= '0;
         pend_data <= '0;
         clr_addr  <= CLR_START;
      end else begin
         if (con_grant) begin
            if (pending) begin
               pending <= 1'b0;
               if (col == COL_LAST) begin
                  col <= '0;
                  row <= row_next;
                  if (row_wrap) begin
                     state    <= ST_CLEAR_ROW;
                     clr_addr <= CLR_START;
                  end
               end else begin
                  col <= col + 1'b1;
               end
            end else if (clr_addr == clr_end) begin
               state <= ST_IDLE;
            end else begin
               clr_addr <= clr_addr + 12'd1;
            end
         end
         if (con_take) begin
            if (printable) begin
               pending   <= 1'b1;
               pend_addr <= cursor_addr;
               pend_data <= con_char;
            end else begin
               case (con_char)
                  CHAR_LF: begin
                     col <= '0;
                     row <= row_next;
                     if (row_wrap) begin
                        state    <= ST_CLEAR_ROW;
                        clr_addr <= CLR_START;
                     end
                  end
                  CHAR_CR: col <= '0;
                  CHAR_FF: begin
                     row      <= ROW_FIRST;
                     col      <= '0;
                     state    <= ST_CLEAR_ALL;
                     clr_addr <= CLR_START;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   terminal_write_arbiter #(
      .MAX_CON_BURST(MAX_CON_BURST)
   ) u_arb (
      .clock     (clock),
      .reset     (reset),
      .con_req   (con_req),
      .con_addr  (con_addr),
      .con_data  (con_data),
      .dbg_write (dbg_write),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data),
      .con_grant (con_grant),
      .dbg_ready (dbg_ready),
      .term_addr (term_addr),
      .term_write(term_write),
      .term_data (term_data)
   );
endmodule
`default_nettype wire

// File: tb/tb_terminal_console_arbiter.sv
`default_nettype none
// tb_terminal_console_arbiter: directed self-checking bench for terminal_console_arbiter.
// Rev 1.0
module tb_terminal_console_arbiter;
   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] dbg_addr;
   logic        dbg_write;
   logic [7:0]  dbg_data;
   logic        dbg_ready;
   logic        con_valid;
   logic [7:0]  con_char;
   logic        con_ready;
   logic [11:0] term_addr;
   logic        term_write;
   logic [7:0]  term_data;

   int tests  = 0;
   int failed = 0;

   logic [11:0] dbg_vec_addr [4] = '{12'd0, 12'd1300, 12'd2399, 12'd7};
   logic [7:0]  dbg_vec_data [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h11};

   terminal_console_arbiter dut (
      .clock     (clock),
      .reset     (reset),
      .dbg_addr  (dbg_addr),
      .dbg_write (dbg_write),
      .dbg_data  (dbg_data),
      .dbg_ready (dbg_ready),
      .con_valid (con_valid),
      .con_char  (con_char),
      .con_ready (con_ready),
      .term_addr (term_addr),
      .term_write(term_write),
      .term_data (term_data)
   );

   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Printable character: one cycle to latch, write visible one cycle after its grant.
   task automatic send_print(input logic [7:0] c, input logic [11:0] a);
      chk("print_ready", con_ready, 1'b1);
      con_valid = 1'b1;
      con_char  = c;
      @(negedge clock);
      con_valid = 1'b0;
      chk("print_latch_no_write", term_write, 1'b0);
      chk("print_busy", con_ready, 1'b0);
      @(negedge clock);
      chk("print_write", {term_write, term_data, term_addr}, {1'b1, c, a});
   endtask

   task automatic send_ctrl(input logic [7:0] c);
      chk("ctrl_ready", con_ready, 1'b1);
      con_valid = 1'b1;
      con_char  = c;
      @(negedge clock);
      con_valid = 1'b0;
      chk("ctrl_no_write", term_write, 1'b0);
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (!con_ready && n < limit) begin
         @(negedge clock);
         n++;
      end
      chk("wait_idle", con_ready, 1'b1);
   endtask

   initial begin
      logic [11:0] clr;
      logic        exp_dbg;
      reset     = 1'b1;
      dbg_write = 1'b0;
      dbg_addr  = '0;
      dbg_data  = '0;
      con_valid = 1'b0;
      con_char  = '0;
      repeat (3) @(negedge clock);
      chk("rst_term_write", term_write, 1'b0);
      chk("rst_term_addr", term_addr, 12'd0);
      chk("rst_term_data", term_data, 8'd0);
      chk("rst_con_ready", con_ready, 1'b0);
      chk("rst_dbg_ready", dbg_ready, 1'b0);

      reset = 1'b0;
      for (int i = 0; i < 1120; i++) begin
         @(negedge clock);
         chk("clr_all_write", {term_write, term_data, term_addr}, {1'b1, 8'h00, 12'(1280 + i)});
         chk("clr_all_ready", con_ready, (i == 1119));
      end
      @(negedge clock);
      chk("idle_no_write", term_write, 1'b0);
      chk("idle_dbg_ready", dbg_ready, 1'b1);

      send_print(8'h48, 12'd1280);
      send_print(8'h69, 12'd1281);
      chk("cursor_col_after_hi", dut.col, 32'd2);
      chk("cursor_row_after_hi", dut.row, 32'd16);

      send_ctrl(8'h0A);
      send_print(8'h41, 12'd1360);
      send_ctrl(8'h0D);
      send_ctrl(8'h01);
      send_print(8'h42, 12'd1360);
      for (int i = 0; i < 12; i++) send_ctrl(8'h0A);
      for (int k = 0; k < 79; k++) send_print(8'(8'h61 + (k % 26)), 12'(2320 + k));
      send_print(8'h5A, 12'd2399);
      for (int i = 0; i < 80; i++) begin
         @(negedge clock);
         chk("clr_row_write", {term_write, term_data, term_addr}, {1'b1, 8'h00, 12'(1280 + i)});
         chk("clr_row_ready", con_ready, (i == 79));
      end
      @(negedge clock);
      chk("clr_row_done", term_write, 1'b0);

      // Debugger held on during the reset clear: 8 console writes, then one debugger write.
      dbg_write = 1'b1;
      dbg_addr  = 12'd5;
      dbg_data  = 8'h77;
      reset     = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      clr   = 12'd1280;
      for (int j = 0; j < 27; j++) begin
         exp_dbg = ((j % 9) == 8);
         chk("burst_dbg_ready", dbg_ready, exp_dbg);
         @(negedge clock);
         if (exp_dbg) begin
            chk("burst_dbg_write", {term_write, term_data, term_addr}, {1'b1, 8'h77, 12'd5});
         end else begin
            chk("burst_con_write", {term_write, term_data, term_addr}, {1'b1, 8'h00, clr});
            clr = clr + 12'd1;
         end
      end
      dbg_write = 1'b0;
      wait_idle(2000);

      for (int k = 0; k < 4; k++) begin
         dbg_write = 1'b1;
         dbg_addr  = dbg_vec_addr[k];
         dbg_data  = dbg_vec_data[k];
         #1;
         chk("dbg_only_ready", dbg_ready, 1'b1);
         @(negedge clock);
         chk("dbg_only_write", {term_write, term_data, term_addr},
             {1'b1, dbg_vec_data[k], dbg_vec_addr[k]});
         chk("dbg_only_con_ready", con_ready, 1'b1);
      end
      dbg_write = 1'b0;
      @(negedge clock);
      chk("dbg_stop_no_write", term_write, 1'b0);
      chk("dbg_stop_addr_hold", term_addr, 12'd7);

      send_print(8'h61, 12'd1280);
      send_print(8'h62, 12'd1281);
      send_ctrl(8'h0C);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("ff_clear_write", {term_write, term_data, term_addr}, {1'b1, 8'h00, 12'(1280 + i)});
      end
      reset = 1'b1;
      @(negedge clock);
      chk("midclr_rst_write", term_write, 1'b0);
      chk("midclr_rst_addr", term_addr, 12'd0);
      chk("midclr_rst_data", term_data, 8'd0);
      chk("midclr_rst_con_ready", con_ready, 1'b0);
      reset = 1'b0;
      @(negedge clock);
      chk("midclr_restart", {term_write, term_data, term_addr}, {1'b1, 8'h00, 12'd1280});
      chk("midclr_cursor_row", dut.row, 32'd16);
      chk("midclr_cursor_col", dut.col, 32'd0);
      wait_idle(2000);
      send_print(8'h51, 12'd1280);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
`default_nettype wire
